// File: rtl/m_dm_multicycle.sv
// m_dm_multicycle: multi-cycle data memory for the MEM stage.
//
// Serves one request at a time over a req/ready handshake. The request
// commits LATENCY cycles after acceptance. Supports word, half and byte
// stores with lane merging, and zero- or sign-extended loads. Misaligned
// and illegal accesses are flagged and do not change the array. After reset
// the whole array is swept to zero before the first request is accepted.
//
// State table:
//   state   | meaning
//   --------+-----------------------------------------------------
//   S_CLEAR | zero-fill sweep, one word per cycle, o_ready low
//   S_IDLE  | waiting for a request, o_ready high
//   S_BUSY  | request latched, latency down-counter running
//
// Ports:
//   i_clk, i_reset_n       clock (rising edge), async active-low reset
//   i_req / o_ready        request strobe / ready (combinational, IDLE only)
//   i_we                   1 = store, 0 = load
//   i_addr                 byte address (wraps modulo array size)
//   i_writeData            right-aligned store data
//   i_dmOp                 000 word, 001 hu, 010 hs, 011 bu, 100 bs
//   i_pc                   issuing PC, used only in the store log
//   o_done / o_exc / o_RD  completion pulse, exception flag, load result
module m_dm_multicycle #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req,
  output logic        o_ready,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_writeData,
  input  logic [2:0]  i_dmOp,
  input  logic [31:0] i_pc,
  output logic        o_done,
  output logic        o_exc,
  output logic [31:0] o_RD
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_BUSY
  } state_t;

  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] p, p_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic commit;

  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [2:0]  req_op;
  logic [31:0] req_pc;

  logic [31:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] widx;
  logic [31:0] cur_word;
  logic [31:0] merged;
  logic [31:0] load_val;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        exc;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [31:0]           mem_wdata;

  assign o_ready = (state == S_IDLE);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= S_CLEAR;
      p     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      p     <= p_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    p_nxt     = p;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    unique case (state)
      S_CLEAR: begin
        p_nxt = p + 1'b1;
        if (&p) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (i_req) begin
          cnt_nxt   = CNT_INIT;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt == 4'd0) begin
          commit    = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      req_we   <= 1'b0;
      req_addr <= '0;
      req_data <= '0;
      req_op   <= '0;
      req_pc   <= '0;
    end else if (state == S_IDLE && i_req) begin
      req_we   <= i_we;
      req_addr <= i_addr;
      req_data <= i_writeData;
      req_op   <= i_dmOp;
      req_pc   <= i_pc;
    end
  end

  // Read-modify-write on the addressed word; upper address bits drop out
  // here, which gives the modulo wrap.
  always_comb begin
    widx     = req_addr[ADDR_WIDTH+1:2];
    cur_word = mem[widx];
    byte_sel = cur_word[{req_addr[1:0], 3'b000} +: 8];
    half_sel = cur_word[{req_addr[1], 4'b0000} +: 16];

    exc = (req_op > 3'd4)
        || (req_op == 3'd0 && req_addr[1:0] != 2'b00)
        || ((req_op == 3'd1 || req_op == 3'd2) && req_addr[0]);

    merged = cur_word;
    unique case (req_op)
      3'd0:       merged = req_data;
      3'd1, 3'd2: merged[{req_addr[1], 4'b0000} +: 16] = req_data[15:0];
      3'd3, 3'd4: merged[{req_addr[1:0], 3'b000} +: 8] = req_data[7:0];
      default:    merged = cur_word;
    endcase

    load_val = '0;
    unique case (req_op)
      3'd0:    load_val = cur_word;
      3'd1:    load_val = {16'b0, half_sel};
      3'd2:    load_val = {{16{half_sel[15]}}, half_sel};
      3'd3:    load_val = {24'b0, byte_sel};
      3'd4:    load_val = {{24{byte_sel[7]}}, byte_sel};
      default: load_val = '0;
    endcase
  end

  // Single write port shared by the sweep and committed stores.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = widx;
    mem_wdata = merged;
    if (state == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = p;
      mem_wdata = '0;
    end else if (commit && req_we && !exc) begin
      mem_we = 1'b1;
    end
  end

  // No reset on the array: the sweep provides the zero fill.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_done <= 1'b0;
      o_exc  <= 1'b0;
      o_RD   <= '0;
    end else begin
      o_done <= commit;
      o_exc  <= commit && exc;
      // Stores keep the previous load result unless they fault.
      if (commit && (exc || !req_we)) o_RD <= exc ? 32'd0 : load_val;
    end
  end

`ifndef SYNTHESIS
  always @(posedge i_clk) begin
    if (i_reset_n && commit && req_we && !exc)
      $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, merged);
  end
`endif

endmodule
